// File: rtl/spi_mem_ctrl.sv
// SPI frame decoder driving a single-port byte memory: address/data writes and two-step reads.
// Optional SPI_MEM_ADDR_AUTOINC_EN: post-increment write/read addresses after each access.
module spi_mem_ctrl #(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {StIdle, StRdIssue, StRdCapt} state_e;

    localparam logic [ADDR_SIZE-1:0] AddrOne = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
    logic                   rd_addr_vld_q, rd_addr_vld_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            rd_addr_vld_q <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 8'h00;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        rd_addr_vld_d = rd_addr_vld_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        err_d         = err_q;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    tx_valid_d = 1'b0;
                    unique case (rx_data[9:8])
                        2'b00: wr_addr_d = rx_data[ADDR_SIZE-1:0];
                        2'b01: begin
                            mem_en_d    = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_addr_q;
                            mem_wdata_d = rx_data[7:0];
`ifdef SPI_MEM_ADDR_AUTOINC_EN
                            wr_addr_d   = wr_addr_q + AddrOne;
`endif
                        end
                        2'b10: begin
                            rd_addr_d     = rx_data[ADDR_SIZE-1:0];
                            rd_addr_vld_d = 1'b1;
                        end
                        2'b11: begin
                            if (rd_addr_vld_q) begin
                                state_d    = StRdIssue;
                                mem_en_d   = 1'b1;
                                mem_addr_d = rd_addr_q;
`ifdef SPI_MEM_ADDR_AUTOINC_EN
                                rd_addr_d  = rd_addr_q + AddrOne;
`endif
                            end else begin
                                // Read without an address: answer zero and flag it.
                                tx_data_d  = 8'h00;
                                tx_valid_d = 1'b1;
                                err_d      = 1'b1;
                            end
                        end
                    endcase
                end
            end
            StRdIssue: begin
                state_d = StRdCapt;
                if (rx_valid) err_d = 1'b1;
            end
            StRdCapt: begin
                state_d    = StIdle;
                tx_data_d  = mem_rdata;
                tx_valid_d = 1'b1;
                if (rx_valid) err_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;

    // AddrOne is only referenced in the auto-increment build.
    logic unused_addr_one;
    assign unused_addr_one = ^AddrOne;

endmodule
